// File: rtl/woz_track_writeback.sv
// Flushes a dirty WOZ track from the track bit buffer to the host as consecutive SD blocks.
// Block 0 starts with an 8-byte header (bit_count LE32, byte_count LE32). Pad bytes past the track end are zero.
module woz_track_writeback #(
   parameter int MAX_BLOCKS = 25,
   parameter int ADDR_W     = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [31:0]       sd_lba,
   output logic              sd_wr,
   input  logic              sd_ack,
   input  logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_din,
   input  logic [6:0]        track,
   input  logic              side,
   input  logic [31:0]       bit_count,
   input  logic              mark_dirty,
   input  logic              flush_req,
   output logic [ADDR_W-1:0] trk_addr,
   input  logic [7:0]        trk_data,
   output logic              dirty,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int          OFF_W     = 14;
   localparam int          REL_W     = OFF_W - 9;
   localparam logic [31:0] MAX_BYTES = 32'(MAX_BLOCKS * 512 - 8);

   localparam logic [1:0] SEL_PAD  = 2'd0;
   localparam logic [1:0] SEL_HDR  = 2'd1;
   localparam logic [1:0] SEL_DATA = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER,
      ST_DONE
   } state_t;

   state_t             state_q;
   logic [31:0]        lba_q;
   logic               wr_q;
   logic               busy_q;
   logic               done_q;
   logic               error_q;
   logic               dirty_q;
   logic               remark_q;
   logic               old_ack_q;
   logic [31:0]        bitcnt_q;
   logic [31:0]        bytecnt_q;
   logic [31:0]        nblk_q;
   logic [REL_W-1:0]   rel_q;
   logic [1:0]         sel_q;
   logic [1:0]         sel_d;
   logic [7:0]         hdr_byte_q;
   logic [7:0]         hdr_byte_d;

   logic [31:0]        bc_in;
   logic [31:0]        nblk_in;
   logic [OFF_W-1:0]   off_w;
   logic [OFF_W-1:0]   toff_w;
   logic [63:0]        hdr_w;
   logic [7:0]         hdr_bytes [8];
   logic               last_blk;
   logic               ack_fall;
   logic               bad_count;

   // Geometry from the live bit_count; only used at the moment a flush is accepted.
   assign bc_in     = (bit_count + 32'd7) >> 3;
   assign nblk_in   = (bc_in + 32'd519) >> 9;
   assign bad_count = (bit_count == 32'd0) || (bc_in > MAX_BYTES);

   assign off_w    = {rel_q, 9'd0} + {{(OFF_W-9){1'b0}}, sd_buff_addr};
   assign toff_w   = off_w - 14'd8;
   assign trk_addr = (off_w < 14'd8) ? '0 : toff_w[ADDR_W-1:0];

   assign hdr_w = {bytecnt_q, bitcnt_q};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_hdr
         assign hdr_bytes[gi] = hdr_w[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      hdr_byte_d = hdr_bytes[off_w[2:0]];
      sel_d      = SEL_DATA;
      if (off_w < 14'd8) begin
         sel_d = SEL_HDR;
      end else if ({{(32-OFF_W){1'b0}}, toff_w} >= bytecnt_q) begin
         sel_d = SEL_PAD;
      end
   end

   // The select is pipelined one clock so it lines up with the RAM's registered read data.
   always_comb begin
      sd_buff_din = 8'h00;
      case (sel_q)
         SEL_HDR:  sd_buff_din = hdr_byte_q;
         SEL_DATA: sd_buff_din = trk_data;
         default:  sd_buff_din = 8'h00;
      endcase
   end

   assign last_blk = ({{(32-REL_W){1'b0}}, rel_q} == (nblk_q - 32'd1));
   assign ack_fall = old_ack_q & ~sd_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         lba_q      <= '0;
         wr_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         dirty_q    <= 1'b0;
         remark_q   <= 1'b0;
         old_ack_q  <= 1'b0;
         bitcnt_q   <= '0;
         bytecnt_q  <= '0;
         nblk_q     <= '0;
         rel_q      <= '0;
         sel_q      <= SEL_PAD;
         hdr_byte_q <= 8'h00;
      end else begin
         done_q     <= 1'b0;
         old_ack_q  <= sd_ack;
         sel_q      <= sel_d;
         hdr_byte_q <= hdr_byte_d;

         // A write landing during a flush must survive that flush's completion.
         if (mark_dirty) begin
            dirty_q <= 1'b1;
            if (state_q != ST_IDLE) begin
               remark_q <= 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (flush_req) begin
                  if (!dirty_q) begin
                     done_q <= 1'b1;
                  end else if (bad_count) begin
                     error_q <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     bitcnt_q  <= bit_count;
                     bytecnt_q <= bc_in;
                     nblk_q    <= nblk_in;
                     lba_q     <= {19'd0, side, track, 5'd0};
                     rel_q     <= '0;
                     error_q   <= 1'b0;
                     remark_q  <= 1'b0;
                     busy_q    <= 1'b1;
                     wr_q      <= 1'b1;
                     state_q   <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (sd_ack) begin
                  wr_q    <= 1'b0;
                  state_q <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (ack_fall) begin
                  if (last_blk) begin
                     state_q <= ST_DONE;
                  end else begin
                     lba_q   <= lba_q + 32'd1;
                     rel_q   <= rel_q + 1'b1;
                     wr_q    <= 1'b1;
                     state_q <= ST_REQ;
                  end
               end
            end
            ST_DONE: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               if (!remark_q && !mark_dirty) begin
                  dirty_q <= 1'b0;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sd_lba = lba_q;
   assign sd_wr  = wr_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign error  = error_q;
   assign dirty  = dirty_q;

endmodule
